// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: assembles big-endian words from the
// UART byte stream and writes them from address 0 while holding the CPU in reset.
module imem_loader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [7:0]        Rx_Byte,
  input  logic              Rx_Valid,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [31:0]       Wr_Data,
  output logic              Cpu_Hold,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W:0]   Word_Count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]        state;
  logic [1:0]        byte_cnt;
  logic [31:0]       shift_reg;
  logic [TW-1:0]     idle_cnt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       next_word;

  assign next_word = {shift_reg[23:0], Rx_Byte};

  // The byte counter wraps 3->0 on the fourth byte, so a byte arriving during
  // WRITE naturally lands as byte 0 of the following word.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      shift_reg  <= '0;
      idle_cnt   <= '0;
      addr       <= '0;
      Wr_En      <= 1'b0;
      Wr_Addr    <= '0;
      Wr_Data    <= '0;
      Cpu_Hold   <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      Word_Count <= '0;
    end else begin
      Done  <= 1'b0;
      Wr_En <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state      <= LOAD;
            Cpu_Hold   <= 1'b1;
            Err        <= 1'b0;
            addr       <= '0;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
            Word_Count <= '0;
          end
        end
        LOAD: begin
          if (Rx_Valid) begin
            shift_reg <= next_word;
            byte_cnt  <= byte_cnt + 2'd1;
            idle_cnt  <= '0;
            if (byte_cnt == 2'd3) begin
              if (next_word == 32'hFFFF_FFFF) begin
                state <= FINISH;
              end else begin
                state   <= WRITE;
                Wr_En   <= 1'b1;
                Wr_Addr <= addr;
                Wr_Data <= next_word;
              end
            end
          end else if (byte_cnt != 2'd0) begin
            // Only a partially received word can time out.
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
              state    <= IDLE;
              Err      <= 1'b1;
              Cpu_Hold <= 1'b0;
              byte_cnt <= '0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end
        end
        WRITE: begin
          addr       <= addr + ADDR_W'(1);
          Word_Count <= Word_Count + (ADDR_W+1)'(1);
          idle_cnt   <= '0;
          if (Rx_Valid) begin
            shift_reg <= next_word;
            byte_cnt  <= byte_cnt + 2'd1;
          end
          if (addr == {ADDR_W{1'b1}}) begin
            state <= FINISH;
          end else begin
            state <= LOAD;
          end
        end
        FINISH: begin
          Done     <= 1'b1;
          Cpu_Hold <= 1'b0;
          byte_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes and Done
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_imem_loader;

  localparam int ADDR_W = 6;

  logic              Clk;
  logic              Rst;
  logic              Start;
  logic [7:0]        Rx_Byte;
  logic              Rx_Valid;
  logic              Wr_En;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [31:0]       Wr_Data;
  logic              Cpu_Hold;
  logic              Done;
  logic              Err;
  logic [ADDR_W:0]   Word_Count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_wc_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(1000)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Rx_Byte(Rx_Byte), .Rx_Valid(Rx_Valid),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Cpu_Hold(Cpu_Hold),
    .Done(Done), .Err(Err), .Word_Count(Word_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    Rx_Byte  = b;
    Rx_Valid = 1'b1;
    @(posedge Clk); #1;
    Rx_Valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[31:24]);
    applyStimulus(w[23:16]);
    applyStimulus(w[15:8]);
    applyStimulus(w[7:0]);
  endtask

  task automatic pulseStart();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic checkResetState();
    checkOutput("rst_wr_en",      32'(Wr_En),      32'h0);
    checkOutput("rst_wr_addr",    32'(Wr_Addr),    32'h0);
    checkOutput("rst_wr_data",    Wr_Data,         32'h0);
    checkOutput("rst_cpu_hold",   32'(Cpu_Hold),   32'h0);
    checkOutput("rst_done",       32'(Done),       32'h0);
    checkOutput("rst_err",        32'(Err),        32'h0);
    checkOutput("rst_word_count", 32'(Word_Count), 32'h0);
  endtask

  logic [31:0] mon_a, mon_d, mon_wc;

  always @(negedge Clk) begin
    if (Wr_En) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                 Wr_Addr, Wr_Data);
      end else begin
        mon_a = exp_addr_q.pop_front();
        mon_d = exp_data_q.pop_front();
        checkOutput("write_addr", 32'(Wr_Addr), mon_a);
        checkOutput("write_data", Wr_Data, mon_d);
        checkOutput("write_cpu_hold", 32'(Cpu_Hold), 32'h1);
      end
    end
    if (Done) begin
      if (exp_wc_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got Done=1, expected 0");
      end else begin
        mon_wc = exp_wc_q.pop_front();
        checkOutput("done_word_count", 32'(Word_Count), mon_wc);
        checkOutput("done_cpu_hold", 32'(Cpu_Hold), 32'h0);
      end
    end
  end

  initial begin
    Rst = 1'b0; Start = 1'b0; Rx_Byte = 8'h00; Rx_Valid = 1'b0;
    idle(3);
    checkResetState();
    Rst = 1'b1;
    idle(2);

    // Two-word image with terminator.
    pulseStart();
    checkOutput("t1_cpu_hold_after_start", 32'(Cpu_Hold), 32'h1);
    expectWrite(0, 32'h2002_0005);
    expectWrite(1, 32'h2003_000c);
    exp_wc_q.push_back(2);
    sendWord(32'h2002_0005);
    idle(2);
    sendWord(32'h2003_000c);
    idle(3);
    checkOutput("t1_cpu_hold_loading", 32'(Cpu_Hold), 32'h1);
    sendWord(32'hFFFF_FFFF);
    idle(4);
    checkOutput("t1_word_count", 32'(Word_Count), 32'd2);
    checkOutput("t1_cpu_hold_end", 32'(Cpu_Hold), 32'h0);

    // Back-to-back bytes with one arriving during WRITE.
    pulseStart();
    expectWrite(0, 32'h10a7_0001);
    expectWrite(1, 32'h1402_0304);
    exp_wc_q.push_back(2);
    sendWord(32'h10a7_0001);
    checkOutput("t2_wr_en_latency", 32'(Wr_En), 32'h1);
    applyStimulus(8'h14);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    idle(2);
    sendWord(32'hFFFF_FFFF);
    idle(4);

    // Fill the whole memory without a terminator.
    pulseStart();
    for (int i = 0; i < 64; i++) begin
      expectWrite(i, 32'h0100_0000 + 32'(i * 3));
    end
    exp_wc_q.push_back(64);
    for (int i = 0; i < 64; i++) begin
      sendWord(32'h0100_0000 + 32'(i * 3));
      idle(1);
    end
    idle(4);
    checkOutput("t3_word_count", 32'(Word_Count), 32'd64);
    checkOutput("t3_cpu_hold", 32'(Cpu_Hold), 32'h0);
    sendWord(32'h1122_3344);
    idle(3);

    // Timeout on a partial word.
    pulseStart();
    applyStimulus(8'h8c);
    applyStimulus(8'h02);
    idle(990);
    checkOutput("t4_err_before_timeout", 32'(Err), 32'h0);
    checkOutput("t4_hold_before_timeout", 32'(Cpu_Hold), 32'h1);
    idle(20);
    checkOutput("t4_err_after_timeout", 32'(Err), 32'h1);
    checkOutput("t4_hold_after_timeout", 32'(Cpu_Hold), 32'h0);
    pulseStart();
    checkOutput("t4_err_cleared", 32'(Err), 32'h0);
    exp_wc_q.push_back(0);
    sendWord(32'hFFFF_FFFF);
    idle(4);
    checkOutput("t4_word_count_empty", 32'(Word_Count), 32'd0);

    // Asynchronous reset mid-load, then bytes in IDLE.
    pulseStart();
    expectWrite(0, 32'hdead_0001);
    expectWrite(1, 32'hdead_0002);
    sendWord(32'hdead_0001);
    sendWord(32'hdead_0002);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    #2;
    Rst = 1'b0;
    #1;
    checkResetState();
    idle(2);
    Rst = 1'b1;
    idle(1);
    sendWord(32'h1234_5678);
    idle(3);
    checkOutput("t5_idle_hold", 32'(Cpu_Hold), 32'h0);

    // Start pulses during LOAD are ignored.
    pulseStart();
    expectWrite(0, 32'haabb_ccdd);
    expectWrite(1, 32'h0000_0007);
    exp_wc_q.push_back(2);
    applyStimulus(8'haa);
    applyStimulus(8'hbb);
    pulseStart();
    applyStimulus(8'hcc);
    applyStimulus(8'hdd);
    pulseStart();
    sendWord(32'h0000_0007);
    sendWord(32'hFFFF_FFFF);
    idle(4);
    checkOutput("t6_word_count", 32'(Word_Count), 32'd2);

    idle(3);
    checkOutput("pending_writes", 32'(exp_addr_q.size()), 32'd0);
    checkOutput("pending_dones", 32'(exp_wc_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the MIPS instruction memory. The core fetches from that memory at run time; this block fills it.
- It takes a byte stream from the UART receiver, assembles big-endian 32-bit words and writes them to consecutive word addresses from 0.
- It holds the CPU in reset while loading. A word of 0xFFFFFFFF terminates the image; this is the fill value of unused memory.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (depth = 2^ADDR_W = 64 words).
- TIMEOUT, 1000, idle clock cycles allowed between bytes of a partial word before aborting.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous reset, active-low.
- Start  input  1  one-cycle pulse that begins a load.
- Rx_Byte  input  8  received byte, qualified by Rx_Valid.
- Rx_Valid  input  1  one-cycle strobe; Rx_Byte is valid this cycle.
- Wr_En  output  1  instruction-memory write strobe.
- Wr_Addr  output  ADDR_W  word address of the write.
- Wr_Data  output  32  word to write.
- Cpu_Hold  output  1  high while loading; the top level ORs it into the CPU reset.
- Done  output  1  one-cycle pulse when a load completes normally.
- Err  output  1  sticky abort flag; cleared by the next Start or by reset.
- Word_Count  output  ADDR_W+1  number of words written by the last load.

Behaviour:
- Reset (Rst=0, asynchronous):
  - State IDLE.
  - Wr_En=0, Wr_Addr=0, Wr_Data=0, Cpu_Hold=0, Done=0, Err=0, Word_Count=0.
  - Internal byte counter=0, shift register=0, timeout counter=0.
- States: IDLE, LOAD, WRITE, FINISH.
- IDLE:
  - Rx_Valid is ignored.
  - Start=1 -> LOAD next cycle, with Cpu_Hold=1, Err=0, address=0, byte counter=0, Word_Count=0.
- LOAD:
  - On Rx_Valid: shift register = {shift[23:0], Rx_Byte}; byte counter increments. The first byte received is the MSB.
  - On the 4th byte, with the assembled word W:
    - W==32'hFFFFFFFF -> FINISH; no write.
    - Otherwise -> WRITE.
  - Start is ignored in LOAD and WRITE.
- WRITE (exactly one cycle):
  - Wr_En=1, Wr_Addr=current address, Wr_Data=W.
  - Next cycle: address+1, Word_Count+1, byte counter=0.
  - If the written address was 2^ADDR_W-1 (memory full) -> FINISH. Otherwise -> LOAD.
  - An Rx_Valid arriving during WRITE is accepted as byte 0 of the next word; no byte is lost.
- FINISH (one cycle):
  - Done=1, Cpu_Hold=0 on the following cycle, -> IDLE.
  - Word_Count holds its value until the next Start.
- Latency: Wr_En asserts the cycle after the Rx_Valid carrying the 4th byte.
- Timeout:
  - In LOAD with byte counter 1..3, the counter increments each cycle without Rx_Valid and clears on Rx_Valid.
  - On reaching TIMEOUT: Err=1, Cpu_Hold=0, -> IDLE, no Done; the partial word is discarded.
  - The counter does not run with byte counter=0. An empty gap between words is legal indefinitely.
- Wr_En is never high outside WRITE. Wr_Addr and Wr_Data hold their last values otherwise.
- Reset mid-load aborts immediately to the reset values. Memory contents already written are left untouched.

Test Plan:
- Start, then bytes 20 02 00 05 20 03 00 0c FF FF FF FF -> two Wr_En pulses: addr0=0x20020005, addr1=0x2003000c; Done pulse; Word_Count=2; Cpu_Hold high from Start until Done.
- Bytes 10 a7 00 01 sent back-to-back with a 5th byte 14 arriving during WRITE -> 0x10a70001 written; 0x14 captured as MSB of the next word.
- 64 non-terminator words, no FF terminator -> writes to addresses 0..63; Done after the address-63 write; Word_Count=64; further bytes ignored.
- Start, bytes 8c 02 then 1000 idle cycles -> Err=1, Cpu_Hold=0, no Wr_En, no Done; next Start clears Err.
- Rst asserted after 2 words of a load -> all outputs to reset values asynchronously; Rx_Valid in IDLE produces no Wr_En.
- Start pulsed again during LOAD -> no effect on address or byte counter; load completes normally.
